// File: rtl/airlock_pkg.sv
// Shared types and constants for the two-door airlock sequencer.
package airlock_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_VENT,
      ST_PRESS,
      ST_OPEN_OUT,
      ST_DWELL_OUT,
      ST_CLOSE_OUT,
      ST_OPEN_IN,
      ST_DWELL_IN,
      ST_CLOSE_IN,
      ST_FAULT
   } state_t;

   localparam logic DIR_ARRIVE = 1'b0;
   localparam logic DIR_DEPART = 1'b1;

   localparam logic [1:0] FC_NONE      = 2'd0;
   localparam logic [1:0] FC_BOTH_OPEN = 2'd1;
   localparam logic [1:0] FC_DOOR_OPEN = 2'd2;
   localparam logic [1:0] FC_TIMEOUT   = 2'd3;

   // A zero-length phase behaves as a single cycle.
   function automatic int unsigned min1(input int unsigned v);
      return (v == 0) ? 1 : v;
   endfunction

endpackage

// File: rtl/airlock_timer.sv
// Shared phase/timeout down-counter: loads on state entry, saturates at zero.
module airlock_timer #(
   parameter int unsigned CNT_W = 3
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Load,
   input  logic [CNT_W-1:0] LoadVal,
   output logic             Expired
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         count <= '0;
      end else if (Load) begin
         count <= LoadVal;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign Expired = (count == '0);

endmodule

// File: rtl/airlock_controller.sv
// Airlock trip sequencer: drives door flips and pump/vent, watches door feedback,
// and latches a sticky fault if both doors could ever be open together.
module airlock_controller
   import airlock_pkg::*;
#(
   parameter int unsigned PRESS_CYCLES = 4,
   parameter int unsigned VENT_CYCLES  = 4,
   parameter int unsigned DWELL_CYCLES = 3,
   parameter int unsigned WAIT_MAX     = 5,
   parameter int unsigned CNT_W        = 3
) (
   input  logic Clock,
   input  logic Reset,
   input  logic ArriveReq,
   input  logic DepartReq,
   input  logic OuterOpen,
   input  logic InnerOpen,
   output logic OuterFlip,
   output logic InnerFlip,
   output logic Pumping,
   output logic Venting,
   output logic Pressurized,
   output logic Busy,
   output logic Fault
);

   state_t           state, state_nxt;
   logic             dir, dir_nxt;
   logic [1:0]       cause;
   logic             expired;
   logic             entering;
   logic [CNT_W-1:0] load_val;

   // Count is loaded with length-1 so expiry lands on the last cycle of the phase.
   function automatic logic [CNT_W-1:0] load_for(input state_t s);
      case (s)
         ST_VENT:      load_for = CNT_W'(min1(VENT_CYCLES) - 1);
         ST_PRESS:     load_for = CNT_W'(min1(PRESS_CYCLES) - 1);
         ST_DWELL_OUT,
         ST_DWELL_IN:  load_for = CNT_W'(min1(DWELL_CYCLES) - 1);
         ST_OPEN_OUT,
         ST_CLOSE_OUT,
         ST_OPEN_IN,
         ST_CLOSE_IN:  load_for = CNT_W'(min1(WAIT_MAX) - 1);
         default:      load_for = '0;
      endcase
   endfunction

   assign entering = (state_nxt != state);
   assign load_val = load_for(state_nxt);

   airlock_timer #(.CNT_W(CNT_W)) u_timer (
      .Clock   (Clock),
      .Reset   (Reset),
      .Load    (entering),
      .LoadVal (load_val),
      .Expired (expired)
   );

   always_comb begin
      state_nxt = state;
      dir_nxt   = dir;
      cause     = FC_NONE;

      if (OuterOpen && InnerOpen) begin
         cause = FC_BOTH_OPEN;
      end else if ((OuterOpen || InnerOpen) &&
                   (state == ST_IDLE || state == ST_VENT || state == ST_PRESS)) begin
         cause = FC_DOOR_OPEN;
      end

      case (state)
         ST_IDLE: begin
            // On a tie, take the trip that starts without a pump phase.
            if (DepartReq && (Pressurized || !ArriveReq)) begin
               dir_nxt   = DIR_DEPART;
               state_nxt = Pressurized ? ST_OPEN_IN : ST_PRESS;
            end else if (ArriveReq) begin
               dir_nxt   = DIR_ARRIVE;
               state_nxt = Pressurized ? ST_VENT : ST_OPEN_OUT;
            end
         end
         ST_VENT:      if (expired) state_nxt = ST_OPEN_OUT;
         ST_PRESS:     if (expired) state_nxt = ST_OPEN_IN;
         ST_OPEN_OUT: begin
            if (OuterOpen)    state_nxt = ST_DWELL_OUT;
            else if (expired) cause     = FC_TIMEOUT;
         end
         ST_DWELL_OUT: if (expired) state_nxt = ST_CLOSE_OUT;
         ST_CLOSE_OUT: begin
            if (!OuterOpen)   state_nxt = (dir == DIR_ARRIVE) ? ST_PRESS : ST_IDLE;
            else if (expired) cause     = FC_TIMEOUT;
         end
         ST_OPEN_IN: begin
            if (InnerOpen)    state_nxt = ST_DWELL_IN;
            else if (expired) cause     = FC_TIMEOUT;
         end
         ST_DWELL_IN:  if (expired) state_nxt = ST_CLOSE_IN;
         ST_CLOSE_IN: begin
            if (!InnerOpen)   state_nxt = (dir == DIR_ARRIVE) ? ST_IDLE : ST_VENT;
            else if (expired) cause     = FC_TIMEOUT;
         end
         ST_FAULT:     state_nxt = ST_FAULT;
         default:      state_nxt = ST_FAULT;
      endcase

      if (cause != FC_NONE) state_nxt = ST_FAULT;
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= ST_IDLE;
         dir         <= DIR_ARRIVE;
         OuterFlip   <= 1'b0;
         InnerFlip   <= 1'b0;
         Pumping     <= 1'b0;
         Venting     <= 1'b0;
         Pressurized <= 1'b1;
         Busy        <= 1'b0;
         Fault       <= 1'b0;
      end else begin
         state     <= state_nxt;
         dir       <= dir_nxt;
         OuterFlip <= entering && (state_nxt == ST_OPEN_OUT || state_nxt == ST_CLOSE_OUT);
         InnerFlip <= entering && (state_nxt == ST_OPEN_IN || state_nxt == ST_CLOSE_IN);
         Pumping   <= (state_nxt == ST_PRESS);
         Venting   <= (state_nxt == ST_VENT);
         Busy      <= (state_nxt != ST_IDLE) && (state_nxt != ST_FAULT);
         Fault     <= (state_nxt == ST_FAULT);
         if (state == ST_VENT && state_nxt == ST_OPEN_OUT) begin
            Pressurized <= 1'b0;
         end else if (state == ST_PRESS && state_nxt == ST_OPEN_IN) begin
            Pressurized <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_airlock_controller.sv
// Bench for airlock_controller: door models, vector table, phase-level trip model, fault cases.
module tb_airlock_controller;

   localparam int PC = 4;
   localparam int VC = 4;
   localparam int DC = 3;

   typedef logic [6:0] out_t;   // {OuterFlip, InnerFlip, Pumping, Venting, Pressurized, Busy, Fault}

   typedef struct {
      logic a;
      logic d;
      out_t first;
      logic p_after;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic arr = 1'b0;
   logic dep = 1'b0;
   logic outer_stuck = 1'b0;
   logic force_inner = 1'b0;
   logic outer_q, inner_q;
   logic outer_open, inner_open;
   logic oflip, iflip, pump, vent, press, busy, fault;

   int   tests = 0;
   int   fails = 0;

   out_t exp_q[$];
   out_t cur_exp;
   bit   cur_idle;
   bit   mp;
   vec_t tbl[7];

   always #5 clk = ~clk;

   // OCPort stand-ins: toggle one cycle after a flip pulse, cleared by reset.
   always @(posedge clk) begin
      if (rst) begin
         outer_q <= 1'b0;
         inner_q <= 1'b0;
      end else begin
         if (oflip && !outer_stuck) outer_q <= ~outer_q;
         if (iflip)                 inner_q <= ~inner_q;
      end
   end

   assign outer_open = outer_q;
   assign inner_open = inner_q | force_inner;

   airlock_controller dut (
      .Clock       (clk),
      .Reset       (rst),
      .ArriveReq   (arr),
      .DepartReq   (dep),
      .OuterOpen   (outer_open),
      .InnerOpen   (inner_open),
      .OuterFlip   (oflip),
      .InnerFlip   (iflip),
      .Pumping     (pump),
      .Venting     (vent),
      .Pressurized (press),
      .Busy        (busy),
      .Fault       (fault)
   );

   function automatic out_t mk(bit o_f, bit i_f, bit pu, bit ve, bit pr, bit bu, bit fa);
      return {o_f, i_f, pu, ve, pr, bu, fa};
   endfunction

   function automatic out_t dut_out();
      return {oflip, iflip, pump, vent, press, busy, fault};
   endfunction

   task automatic chk(input string name, input out_t act, input out_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k = 0;
      while (busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (busy) begin
         tests++;
         fails++;
         $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
      end
   endtask

   task automatic wait_sig(input string name, input int which, input int budget);
      int k = 0;
      while (((which == 0) ? !oflip : !outer_open) && k < budget) begin
         @(negedge clk);
         k++;
      end
      if ((which == 0) ? !oflip : !outer_open) begin
         tests++;
         fails++;
         $display("FAIL %s: event not seen within %0d cycles", name, budget);
      end
   endtask

   // Phase-level trip model: each phase contributes a run of expected cycles.
   task automatic push_n(input int n, input out_t r);
      for (int i = 0; i < n; i++) exp_q.push_back(r);
   endtask

   task automatic push_vent();
      push_n(VC, mk(0, 0, 0, 1, mp, 1, 0));
      mp = 1'b0;
   endtask

   task automatic push_pump();
      push_n(PC, mk(0, 0, 1, 0, mp, 1, 0));
      mp = 1'b1;
   endtask

   task automatic push_door(input bit outer);
      out_t flip = outer ? mk(1, 0, 0, 0, mp, 1, 0) : mk(0, 1, 0, 0, mp, 1, 0);
      out_t hold = mk(0, 0, 0, 0, mp, 1, 0);
      exp_q.push_back(flip);
      exp_q.push_back(hold);
      push_n(DC, hold);
      exp_q.push_back(flip);
      exp_q.push_back(hold);
   endtask

   task automatic build_trip(input bit a, input bit d);
      bit go_depart = d && (mp || !a);
      if (go_depart) begin
         if (!mp) push_pump();
         push_door(1'b0);
         push_vent();
         push_door(1'b1);
      end else begin
         if (mp) push_vent();
         push_door(1'b1);
         push_pump();
         push_door(1'b0);
      end
   endtask

   // mode 0: random requests, 1: both held high, 2: no requests
   task automatic engine(input int n, input int mode);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         chk($sformatf("trace_m%0d_c%0d", mode, c), dut_out(), cur_exp);
         case (mode)
            0: begin
               arr = ($urandom_range(0, 9) == 0);
               dep = ($urandom_range(0, 9) == 0);
            end
            1: begin
               arr = 1'b1;
               dep = 1'b1;
            end
            default: begin
               arr = 1'b0;
               dep = 1'b0;
            end
         endcase
         if (cur_idle && (arr || dep)) build_trip(arr, dep);
         if (exp_q.size() > 0) begin
            cur_exp  = exp_q.pop_front();
            cur_idle = 1'b0;
         end else begin
            cur_exp  = mk(0, 0, 0, 0, mp, 0, 0);
            cur_idle = 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      outer_stuck = 1'b0;
      force_inner = 1'b0;
   endtask

   task automatic start_arrival();
      @(negedge clk);
      arr = 1'b1;
      @(negedge clk);
      arr = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b0, 1'b0, mk(0, 0, 0, 0, 1, 0, 0), 1'b1};
      tbl[1] = '{1'b1, 1'b1, mk(0, 1, 0, 0, 1, 1, 0), 1'b0};
      tbl[2] = '{1'b1, 1'b1, mk(1, 0, 0, 0, 0, 1, 0), 1'b1};
      tbl[3] = '{1'b1, 1'b0, mk(0, 0, 0, 1, 1, 1, 0), 1'b1};
      tbl[4] = '{1'b0, 1'b1, mk(0, 1, 0, 0, 1, 1, 0), 1'b0};
      tbl[5] = '{1'b0, 1'b1, mk(0, 0, 1, 0, 0, 1, 0), 1'b0};
      tbl[6] = '{1'b1, 1'b0, mk(1, 0, 0, 0, 0, 1, 0), 1'b1};

      repeat (3) @(negedge clk);
      chk("reset_state", dut_out(), mk(0, 0, 0, 0, 1, 0, 0));
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         arr = tbl[i].a;
         dep = tbl[i].d;
         @(negedge clk);
         arr = 1'b0;
         dep = 1'b0;
         chk($sformatf("vec%0d_first", i), dut_out(), tbl[i].first);
         wait_idle($sformatf("vec%0d_done", i), 60);
         chk($sformatf("vec%0d_end", i), dut_out(), mk(0, 0, 0, 0, tbl[i].p_after, 0, 0));
      end

      mp       = 1'b1;
      cur_exp  = mk(0, 0, 0, 0, 1, 0, 0);
      cur_idle = 1'b1;
      engine(1200, 0);
      engine(40, 2);
      engine(80, 1);
      engine(40, 2);

      // Reset while the outer door is dwelling open
      do_reset();
      start_arrival();
      wait_sig("rst_wait_open", 1, 20);
      @(negedge clk);
      chk("rst_in_dwell", dut_out(), mk(0, 0, 0, 0, 0, 1, 0));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_trip", dut_out(), mk(0, 0, 0, 0, 1, 0, 0));
      @(negedge clk);
      chk("rst_then_idle", dut_out(), mk(0, 0, 0, 0, 1, 0, 0));

      // Inner door forced open while outer is open
      start_arrival();
      wait_sig("both_wait_open", 1, 20);
      @(negedge clk);
      chk("both_pre", dut_out(), mk(0, 0, 0, 0, 0, 1, 0));
      force_inner = 1'b1;
      @(negedge clk);
      chk("both_open_fault", dut_out(), mk(0, 0, 0, 0, 0, 0, 1));
      force_inner = 1'b0;
      do_reset();

      // Outer door never reports open
      outer_stuck = 1'b1;
      start_arrival();
      wait_sig("to_wait_flip", 0, 20);
      chk("to_cycle1", dut_out(), mk(1, 0, 0, 0, 0, 1, 0));
      for (int i = 2; i <= 5; i++) begin
         @(negedge clk);
         chk($sformatf("to_cycle%0d", i), dut_out(), mk(0, 0, 0, 0, 0, 1, 0));
      end
      @(negedge clk);
      chk("to_fault", dut_out(), mk(0, 0, 0, 0, 0, 0, 1));
      arr = 1'b1;
      dep = 1'b1;
      repeat (4) @(negedge clk);
      chk("fault_sticky", dut_out(), mk(0, 0, 0, 0, 0, 0, 1));
      arr = 1'b0;
      dep = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      outer_stuck = 1'b0;
      chk("fault_cleared", dut_out(), mk(0, 0, 0, 0, 1, 0, 0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
